// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_e;

  localparam int unsigned I2S_MODE_PHILIPS = 0;
  localparam int unsigned I2S_MODE_LJ      = 1;

endpackage

// File: rtl/i2s_ch_track.sv
// Effective-channel tracker: derives ch from WS per framing mode and flags slot boundaries.
module i2s_ch_track
  import i2s_pkg::*;
#(
  parameter int unsigned MODE = I2S_MODE_PHILIPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic ws,
  output logic ch,
  output logic boundary
);

  logic ws_d;
  logic ch_d;
  logic hist_ok;

  // Philips framing delays the channel by one bit relative to WS
  assign ch       = (MODE == I2S_MODE_LJ) ? ws : ws_d;
  assign boundary = in_valid && hist_ok && (ch != ch_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_d    <= 1'b0;
      ch_d    <= 1'b0;
      hist_ok <= 1'b0;
    end else if (in_valid) begin
      ws_d    <= ws;
      ch_d    <= ch;
      hist_ok <= 1'b1;
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receiver/deserialiser: frame-locks on right->left, assembles MSB-first words, emits L/R pairs.
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MODE   = I2S_MODE_PHILIPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              SD,
  input  logic              WS,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              short_err
);

  localparam int unsigned       CW      = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     FULL    = CW'(DATA_W);
  localparam logic [CW-1:0]     LAST    = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

  i2s_state_e        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] left_hold, left_hold_n;
  logic [DATA_W-1:0] left_n, right_n;
  logic [DATA_W-1:0] word, fin_word;
  logic              left_ok, left_ok_n;
  logic              valid_n, short_n, fin;
  logic              ch, boundary;

  i2s_ch_track #(.MODE(MODE)) u_track (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .ws       (WS),
    .ch       (ch),
    .boundary (boundary)
  );

  // Bits are placed directly at their final position, so a partial word is already left-aligned
  assign word = shreg | (SD ? (MSB_ONE >> cnt) : '0);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    left_hold_n = left_hold;
    left_ok_n   = left_ok;
    left_n      = out_left;
    right_n     = out_right;
    valid_n     = 1'b0;
    short_n     = 1'b0;
    fin         = 1'b0;
    fin_word    = shreg;
    if (in_valid) begin
      if (boundary && ((state != SYNC) || !ch)) begin
        // a short slot completes and the new slot's MSB loads on the same edge
        if ((state != SYNC) && (cnt != FULL)) begin
          short_n  = 1'b1;
          fin      = 1'b1;
          fin_word = shreg;
        end
        state_n = ch ? RIGHT : LEFT;
        if (!ch) left_ok_n = 1'b0;
        shreg_n = SD ? MSB_ONE : '0;
        cnt_n   = CW'(1);
      end else if ((state != SYNC) && (cnt != FULL)) begin
        shreg_n = word;
        cnt_n   = cnt + 1'b1;
        if (cnt == LAST) begin
          fin      = 1'b1;
          fin_word = word;
        end
      end
    end
    if (fin) begin
      if (state == LEFT) begin
        left_hold_n = fin_word;
        left_ok_n   = 1'b1;
      end else if ((state == RIGHT) && left_ok) begin
        left_n    = left_hold;
        right_n   = fin_word;
        valid_n   = 1'b1;
        left_ok_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      short_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      left_hold <= left_hold_n;
      left_ok   <= left_ok_n;
      out_valid <= valid_n;
      out_left  <= left_n;
      out_right <= right_n;
      short_err <= short_n;
    end
  end

endmodule
